// File: rtl/maxpool_2x2.sv
// 2x2 stride-2 max pooling of a finished convolution result map into an output buffer.
// Build option MAXPOOL_RELU_EN: clamp negative source samples to 0 before pooling (fused ReLU).
//
// state | meaning
// IDLE  | waiting for start
// READ  | issuing the four window reads, k = 0..3
// DRAIN | last read data returning, no read issued
// WRITE | pooled maximum written to the destination buffer
// DONE  | one-cycle completion pulse
module maxpool_2x2 #(
    parameter int BIT_DEPTH  = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int IMG_W      = 26,
    parameter int IMG_H      = 26
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  src_rd_en,
    output logic [ADDR_WIDTH-1:0] src_rd_addr,
    input  logic [BIT_DEPTH-1:0]  src_data,
    output logic                  dst_wr_en,
    output logic [ADDR_WIDTH-1:0] dst_addr,
    output logic [BIT_DEPTH-1:0]  dst_data
);

    localparam int OW = IMG_W / 2;
    localparam int OH = IMG_H / 2;
    localparam logic [ADDR_WIDTH-1:0] OW_LAST = ADDR_WIDTH'(OW - 1);
    localparam logic [ADDR_WIDTH-1:0] OH_LAST = ADDR_WIDTH'(OH - 1);
    localparam logic [ADDR_WIDTH-1:0] W_A     = ADDR_WIDTH'(IMG_W);
    localparam logic [ADDR_WIDTH-1:0] OW_A    = ADDR_WIDTH'(OW);

    typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              k_q, k_d;
    logic [ADDR_WIDTH-1:0]   prow_q, prow_d;
    logic [ADDR_WIDTH-1:0]   pcol_q, pcol_d;
    logic [BIT_DEPTH-1:0]    max_q, max_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    src_rd_en_q, src_rd_en_d;
    logic [ADDR_WIDTH-1:0]   src_rd_addr_q, src_rd_addr_d;
    logic                    dst_wr_en_q, dst_wr_en_d;
    logic [ADDR_WIDTH-1:0]   dst_addr_q, dst_addr_d;
    logic [BIT_DEPTH-1:0]    dst_data_q, dst_data_d;
    logic [BIT_DEPTH-1:0]    sample;
    logic [ADDR_WIDTH-1:0]   row_a, col_a;

    always_comb begin
        sample = src_data;
`ifdef MAXPOOL_RELU_EN
        if (src_data[BIT_DEPTH-1]) sample = '0;
`else
`endif
        state_d = state_q;
        k_d     = k_q;
        prow_d  = prow_q;
        pcol_d  = pcol_q;
        max_d   = max_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    k_d     = 2'd0;
                    prow_d  = '0;
                    pcol_d  = '0;
                end
            end
            READ: begin
                // Data seen in slot k belongs to the read issued in slot k-1.
                if (k_q == 2'd1) begin
                    max_d = sample;
                end else if (k_q != 2'd0 && $signed(sample) > $signed(max_q)) begin
                    max_d = sample;
                end
                if (k_q == 2'd3) begin
                    state_d = DRAIN;
                    k_d     = 2'd0;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            DRAIN: begin
                if ($signed(sample) > $signed(max_q)) max_d = sample;
                state_d = WRITE;
            end
            WRITE: begin
                if (pcol_q < OW_LAST) begin
                    pcol_d  = pcol_q + 1'b1;
                    state_d = READ;
                end else if (prow_q < OH_LAST) begin
                    pcol_d  = '0;
                    prow_d  = prow_q + 1'b1;
                    state_d = READ;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Registered outputs are derived from the next state.
        busy_d      = (state_d == READ) || (state_d == DRAIN) || (state_d == WRITE);
        done_d      = (state_d == DONE);
        src_rd_en_d = (state_d == READ);
        dst_wr_en_d = (state_d == WRITE);

        row_a         = {prow_d[ADDR_WIDTH-2:0], k_d[1]};
        col_a         = {pcol_d[ADDR_WIDTH-2:0], k_d[0]};
        src_rd_addr_d = src_rd_addr_q;
        if (state_d == READ) src_rd_addr_d = row_a * W_A + col_a;

        dst_addr_d = dst_addr_q;
        dst_data_d = dst_data_q;
        if (state_d == WRITE) begin
            dst_addr_d = prow_q * OW_A + pcol_q;
            dst_data_d = max_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            k_q           <= '0;
            prow_q        <= '0;
            pcol_q        <= '0;
            max_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            src_rd_en_q   <= 1'b0;
            src_rd_addr_q <= '0;
            dst_wr_en_q   <= 1'b0;
            dst_addr_q    <= '0;
            dst_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            prow_q        <= prow_d;
            pcol_q        <= pcol_d;
            max_q         <= max_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            src_rd_en_q   <= src_rd_en_d;
            src_rd_addr_q <= src_rd_addr_d;
            dst_wr_en_q   <= dst_wr_en_d;
            dst_addr_q    <= dst_addr_d;
            dst_data_q    <= dst_data_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign src_rd_en   = src_rd_en_q;
    assign src_rd_addr = src_rd_addr_q;
    assign dst_wr_en   = dst_wr_en_q;
    assign dst_addr    = dst_addr_q;
    assign dst_data    = dst_data_q;

endmodule

// File: tb/tb_maxpool_2x2.sv
// Randomized self-checking bench for maxpool_2x2 against a window-maximum reference model.
module tb_maxpool_2x2;

    localparam int W      = 26;
    localparam int H      = 26;
    localparam int OW     = W / 2;
    localparam int OH     = H / 2;
    localparam int NOUT   = OW * OH;
    localparam int T_DONE = NOUT * 6 + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy, done, src_rd_en, dst_wr_en;
    logic [9:0] src_rd_addr, dst_addr;
    logic [7:0] src_data;
    logic [7:0] dst_data;

    logic [7:0] mem [0:1023];
    int         exp_out [NOUT];
    int         got [NOUT];
    int         n_tests = 0;
    int         n_fail  = 0;

    maxpool_2x2 dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .src_rd_en(src_rd_en), .src_rd_addr(src_rd_addr), .src_data(src_data),
        .dst_wr_en(dst_wr_en), .dst_addr(dst_addr), .dst_data(dst_data)
    );

    always #5 clk = ~clk;

    initial src_data = 8'h00;
    always @(posedge clk) if (src_rd_en) src_data <= mem[src_rd_addr];

    task automatic chk(input string tag, input int got_v, input int exp_v);
        n_tests++;
        if (got_v != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
        end
    endtask

    task automatic build_model();
        for (int pr = 0; pr < OH; pr++) begin
            for (int pc = 0; pc < OW; pc++) begin
                int m = -1000;
                for (int dr = 0; dr < 2; dr++) begin
                    for (int dc = 0; dc < 2; dc++) begin
                        int v = int'($signed(mem[(2*pr+dr)*W + 2*pc+dc]));
`ifdef MAXPOOL_RELU_EN
                        if (v < 0) v = 0;
`endif
                        if (v > m) m = v;
                    end
                end
                exp_out[pr*OW + pc] = m & 255;
            end
        end
    endtask

    task automatic fill_random(input int lo, input int hi);
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom_range(hi, lo));
    endtask

    task automatic do_run(input string tag, input int dup_at, input int abort_at);
        int n = 0, origin = 0, wcount = 0, first_addr = -1, first_wr = -1;
        int done_cyc = -1, done_cnt = 0, w_at_abort = 0;
        bit finished = 0;
        for (int i = 0; i < NOUT; i++) got[i] = -1;
        build_model();
        @(negedge clk);
        start = 1'b1;
        while (!finished && n < origin + T_DONE + 300) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            rst   = 1'b0;
            if (n - origin == 1) begin
                chk({tag, " busy_after_start"}, int'(busy), 1);
                chk({tag, " rd_en_after_start"}, int'(src_rd_en), 1);
            end
            if (dst_wr_en) begin
                if (wcount == 0) begin
                    first_addr = int'(dst_addr);
                    first_wr   = n - origin;
                end
                if (int'(dst_addr) < NOUT) got[dst_addr] = int'(dst_data);
                wcount++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = n - origin;
            end
            if (dup_at > 0 && n == dup_at) start = 1'b1;
            if (abort_at > 0) begin
                if (n == abort_at) rst = 1'b1;
                if (n == abort_at + 1) begin
                    chk({tag, " outputs_after_rst"},
                        int'({busy, done, src_rd_en, dst_wr_en, src_rd_addr, dst_addr, dst_data}), 0);
                    w_at_abort = wcount;
                end
                if (n == abort_at + 10) begin
                    chk({tag, " writes_while_aborted"}, wcount, w_at_abort);
                    chk({tag, " done_of_aborted_run"}, done_cnt, 0);
                    start = 1'b1;
                    origin = n;
                    wcount = 0; done_cnt = 0; done_cyc = -1; first_addr = -1; first_wr = -1;
                    for (int i = 0; i < NOUT; i++) got[i] = -1;
                end
            end
            if (done_cnt > 0 && n - origin >= done_cyc + 3) finished = 1;
        end
        chk({tag, " done_count"}, done_cnt, 1);
        chk({tag, " done_cycle"}, done_cyc, T_DONE);
        chk({tag, " write_count"}, wcount, NOUT);
        chk({tag, " first_addr"}, first_addr, 0);
        chk({tag, " first_write_cycle"}, first_wr, 6);
        chk({tag, " busy_after_done"}, int'(busy), 0);
        for (int i = 0; i < NOUT; i++) chk($sformatf("%s out[%0d]", tag, i), got[i], exp_out[i]);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_outputs",
            int'({busy, done, src_rd_en, dst_wr_en, src_rd_addr, dst_addr, dst_data}), 0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk($sformatf("idle[%0d]", c), int'({busy, done, src_rd_en, dst_wr_en}), 0);
        end

        for (int i = 0; i < 1024; i++) mem[i] = 8'(i % 100);
        do_run("mod100", 0, 0);
        chk("mod100 addr0", got[0], 27);
        chk("mod100 addr1", got[1], 29);
        chk("mod100 addr13", got[13], 79);

        fill_random(0, 255);
        mem[0] = 8'hFB; mem[1] = 8'hFD; mem[W] = 8'hF8; mem[W+1] = 8'hFF;
        do_run("negwin", 0, 0);
`ifdef MAXPOOL_RELU_EN
        chk("negwin addr0", got[0], 0);
`else
        chk("negwin addr0", got[0], 255);
`endif

        fill_random(0, 255);
        mem[0] = 8'd3; mem[1] = 8'd127; mem[W] = 8'h80; mem[W+1] = 8'd127;
        do_run("signed", 0, 0);
        chk("signed addr0", got[0], 127);

        fill_random(0, 255);
        do_run("rand_a", 0, 0);
        fill_random(128, 255);
        do_run("rand_neg", 0, 0);

        for (int i = 0; i < 1024; i++) mem[i] = 8'(i % 100);
        do_run("dup_start", 49, 0);

        fill_random(0, 255);
        do_run("abort", 0, 299);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/maxpool_2x2.md
Name: maxpool_2x2

Overview:
- Downstream stage of the convolution engine: reads a finished convolution result map out of a result buffer and produces a 2x2, stride-2 max-pooled map into an output buffer.
- Sits after the convolution engine and its result buffers; it is started once the convolution engine has pulsed done.
- Interfaces:
  - Synchronous-read port (1-cycle latency) on the source result buffer.
  - Single-cycle write port on the destination buffer.

Parameters:
- BIT_DEPTH, 8, width of each result sample; samples are signed two's complement.
- ADDR_WIDTH, 10, width of source and destination addresses.
- IMG_W, 26, width of the source map in samples.
- IMG_H, 26, height of the source map in samples.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that begins pooling one full map.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse after the last pooled sample is written.
- src_rd_en  output  1  read strobe to the source result buffer.
- src_rd_addr  output  ADDR_WIDTH  source address, row*IMG_W + col.
- src_data  input  BIT_DEPTH  source sample, valid the cycle after src_rd_en.
- dst_wr_en  output  1  write strobe to the destination buffer.
- dst_addr  output  ADDR_WIDTH  destination address, prow*(IMG_W/2) + pcol.
- dst_data  output  BIT_DEPTH  pooled maximum.

Behaviour:
- Reset:
  - state=IDLE.
  - busy, done, src_rd_en, dst_wr_en = 0.
  - src_rd_addr, dst_addr, dst_data = 0.
  - window counters and max register = 0.
- Output map size is OW=IMG_W/2 by OH=IMG_H/2 (floor). For odd IMG_W/IMG_H, the last source column/row is ignored.
- States:
  - IDLE: start=1 -> READ with k=0, prow=0, pcol=0, busy=1.
  - READ:
    - Four cycles, k=0..3.
    - src_rd_en=1.
    - Address for k=0,1,2,3 is (2prow,2pcol), (2prow,2pcol+1), (2prow+1,2pcol), (2prow+1,2pcol+1).
    - Leaves to DRAIN after k=3.
  - DRAIN: one cycle, src_rd_en=0; captures the 4th sample.
  - WRITE:
    - One cycle, dst_wr_en=1, dst_addr=prow*OW+pcol, dst_data=max.
    - If pcol<OW-1: pcol++, go to READ.
    - Else if prow<OH-1: pcol=0, prow++, go to READ.
    - Else go to DONE.
  - DONE: done=1, busy=0 this cycle; next cycle -> IDLE.
- Max datapath:
  - Sample returned in READ k=1 (the k=0 read) loads the max register unconditionally.
  - Samples returned in READ k=2, READ k=3 and DRAIN are compared signed; the max register takes the larger value.
  - Ties keep the current value.
- Timing:
  - 6 cycles per window.
  - First dst_wr_en occurs 6 cycles after the start cycle.
  - Full map = OW*OH*6 cycles + 1 DONE cycle. For 26x26: 169 writes, done asserted 1015 cycles after start.
- Outputs are registered. dst_addr and dst_data are held between writes; they change only on WRITE entry.
- start while busy (READ/DRAIN/WRITE/DONE) is ignored.
- start in the same cycle as rst: reset wins.
- rst mid-operation: abort immediately to reset values, no further reads or writes, no done pulse.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. Requirement: IMG_W*IMG_H <= 2^ADDR_WIDTH.

Optional Feature:
- Macro: MAXPOOL_RELU_EN.
- Defined:
  - Each src_data sample is clamped to 0 if negative before entering the max datapath (fused ReLU).
  - dst_data is therefore never negative; an all-negative window writes 0.
- Undefined:
  - Raw signed samples are compared.
  - An all-negative window writes the least-negative value.

Test Plan:
- Reset then idle, no start -> busy=0, done=0, src_rd_en=0, dst_wr_en=0 for 20 cycles.
- Source holds value = (addr mod 100), start -> 169 writes.
  - dst_addr 0 gets 27.
  - dst_addr 1 gets 29.
  - dst_addr 13 gets 79 (addr 79).
  - done exactly 1015 cycles after start.
- Window (0,0) loaded with {-5,-3,-8,-1} (0xFB,0xFD,0xF8,0xFF):
  - Without MAXPOOL_RELU_EN -> dst_data at addr 0 = 0xFF.
  - With MAXPOOL_RELU_EN -> 0x00.
- Window (0,0) = {3,127,-128,127} -> dst_data=127 (signed compare, not 0x80).
- Second start pulse at cycle 50 of a run -> ignored; write count and done timing are unchanged (169 writes, done at 1015).
- rst asserted for 1 cycle at cycle 300, then start at cycle 310:
  - Outputs return to reset values the cycle after rst.
  - No done pulse for the aborted run.
  - New run writes addr 0 first, and done arrives 1015 cycles after cycle 310.
